// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: memory-access encodings,
// LSU state type, and helpers that derive byte lanes and misalignment
// from the access size and the byte offset within a word.
package load_store_unit_pkg;

  // Access size/sign encodings carried on MEM_Control.
  typedef enum logic [2:0] {
    MEM_BYTE              = 3'b000,
    MEM_HALFWORD          = 3'b001,
    MEM_WORD              = 3'b010,
    MEM_BYTE_UNSIGNED     = 3'b100,
    MEM_HALFWORD_UNSIGNED = 3'b101
  } mem_control_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  function automatic logic mem_control_valid(input logic [2:0] mc);
    case (mc)
      MEM_BYTE, MEM_HALFWORD, MEM_WORD,
      MEM_BYTE_UNSIGNED, MEM_HALFWORD_UNSIGNED: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // Byte lanes spanning two consecutive words: [3:0] first word, [7:4] second.
  function automatic logic [7:0] byte_mask(input logic [2:0] mc, input logic [1:0] off);
    logic [3:0] size_mask;
    case (mc)
      MEM_BYTE, MEM_BYTE_UNSIGNED:         size_mask = 4'b0001;
      MEM_HALFWORD, MEM_HALFWORD_UNSIGNED: size_mask = 4'b0011;
      MEM_WORD:                            size_mask = 4'b1111;
      default:                             size_mask = 4'b0000;
    endcase
    return {4'b0000, size_mask} << off;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] mc, input logic [1:0] off);
    case (mc)
      MEM_HALFWORD, MEM_HALFWORD_UNSIGNED: return (off == 2'd3);
      MEM_WORD:                            return (off != 2'd0);
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_data_formatter.sv
// Combinational load-result formatter.
// Ports: hi/lo - second and first memory words of the access,
//        off - byte offset of the access within lo, mem_control - size/sign,
//        data - right-justified, sign- or zero-extended load value
//        (0 for an unknown encoding).
module load_data_formatter
  import load_store_unit_pkg::*;
(
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [1:0]  off,
  input  logic [2:0]  mem_control,
  output logic [31:0] data
);

  logic [63:0] merged_s;
  logic [31:0] shifted_s;

  // Align the addressed bytes to bit 0, then extend to 32 bits.
  always_comb begin
    merged_s  = {hi, lo} >> {off, 3'b000};
    shifted_s = merged_s[31:0];
    case (mem_control)
      MEM_BYTE:              data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      MEM_HALFWORD:          data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      MEM_WORD:              data = shifted_s;
      MEM_BYTE_UNSIGNED:     data = {24'd0, shifted_s[7:0]};
      MEM_HALFWORD_UNSIGNED: data = {16'd0, shifted_s[15:0]};
      default:               data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit. Accepts one load/store per instruction, issues
// word-aligned data-memory requests with byte enables, splits accesses that
// straddle a word boundary into two transactions, and returns the extended
// load result with a one-cycle LSU_Done pulse.
// Ports: CLK/RST_N clock and async active-low reset;
//        LSU_Req/LSU_W_En/MEM_Control/Addr/W_Data request from EX/MEM;
//        LSU_Busy stall, LSU_Done completion, LSU_Misaligned unsplit-misaligned flag,
//        Data_Out load result; DM_* data-memory request/response port.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  LSU_Req,
  input  logic                  LSU_W_En,
  input  logic [2:0]            MEM_Control,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           W_Data,
  output logic                  LSU_Busy,
  output logic                  LSU_Done,
  output logic                  LSU_Misaligned,
  output logic [31:0]           Data_Out,
  output logic                  DM_Req,
  output logic                  DM_W_En,
  output logic [ADDR_WIDTH-1:0] DM_Addr,
  output logic [3:0]            DM_Byte_En,
  output logic [31:0]           DM_W_Data,
  input  logic                  DM_Ack,
  input  logic [31:0]           DM_R_Data
);

  lsu_state_t state_r, state_next_s;

  // Registered copy of the accepted request.
  logic                  store_r;
  logic [2:0]            mc_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           wdata_r;
  logic                  split_r;
  logic                  skip_r;
  logic                  misal_r;
  logic [31:0]           lo_r;
  logic [31:0]           hi_r;

  logic                  dm_req_r;
  logic                  dm_w_en_r;
  logic [ADDR_WIDTH-1:0] dm_addr_r;
  logic [3:0]            dm_be_r;
  logic [31:0]           dm_wdata_r;
  logic                  lsu_done_r;
  logic                  lsu_mis_r;
  logic [31:0]           data_out_r;

  logic                  accept_s;
  logic                  in_misal_s;
  logic                  in_skip_s;
  logic                  src_store_s;
  logic [2:0]            src_mc_s;
  logic [ADDR_WIDTH-1:0] src_addr_s;
  logic [31:0]           src_wdata_s;
  logic [1:0]            src_off_s;
  logic [ADDR_WIDTH-1:0] word_addr_s;
  logic [7:0]            be8_s;
  logic [63:0]           wd64_s;
  logic [31:0]           fmt_data_s;

  // Request qualification; the request still held during the LSU_Done cycle
  // is the completed one, so it must not be taken again.
  always_comb begin
    accept_s   = LSU_Req & ~lsu_done_r;
    in_misal_s = mem_control_valid(MEM_Control) & is_misaligned(MEM_Control, Addr[1:0]);
    in_skip_s  = ~mem_control_valid(MEM_Control) | (in_misal_s & ~SPLIT_MISALIGNED);
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = in_skip_s ? DONE : ACC1;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACC1: begin
        if (DM_Ack) begin
          state_next_s = split_r ? ACC2 : DONE;
        end else begin
          state_next_s = ACC1;
        end
      end
      ACC2: begin
        if (DM_Ack) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ACC2;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Request fields come straight from the inputs on the accept edge so the
  // first DM request can be registered in the same cycle.
  always_comb begin
    if (state_r == IDLE) begin
      src_store_s = LSU_W_En;
      src_mc_s    = MEM_Control;
      src_addr_s  = Addr;
      src_wdata_s = W_Data;
    end else begin
      src_store_s = store_r;
      src_mc_s    = mc_r;
      src_addr_s  = addr_r;
      src_wdata_s = wdata_r;
    end
    src_off_s   = src_addr_s[1:0];
    word_addr_s = {src_addr_s[ADDR_WIDTH-1:2], 2'b00};
    be8_s       = byte_mask(src_mc_s, src_off_s);
    wd64_s      = {32'd0, src_wdata_s} << {src_off_s, 3'b000};
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture of the accepted request and of the returned read words.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      store_r <= 1'b0;
      mc_r    <= 3'b000;
      addr_r  <= '0;
      wdata_r <= 32'd0;
      split_r <= 1'b0;
      skip_r  <= 1'b0;
      misal_r <= 1'b0;
      lo_r    <= 32'd0;
      hi_r    <= 32'd0;
    end else if (state_r == IDLE && accept_s) begin
      store_r <= LSU_W_En;
      mc_r    <= MEM_Control;
      addr_r  <= Addr;
      wdata_r <= W_Data;
      split_r <= in_misal_s;
      skip_r  <= in_skip_s;
      misal_r <= in_misal_s;
      lo_r    <= 32'd0;
      hi_r    <= 32'd0;
    end else if (state_r == ACC1 && DM_Ack) begin
      lo_r <= DM_R_Data;
    end else if (state_r == ACC2 && DM_Ack) begin
      hi_r <= DM_R_Data;
    end else begin
      lo_r <= lo_r;
    end
  end

  // Data-memory request outputs, registered from the next state so they
  // stay stable while waiting for DM_Ack.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dm_req_r   <= 1'b0;
      dm_w_en_r  <= 1'b0;
      dm_addr_r  <= '0;
      dm_be_r    <= 4'b0000;
      dm_wdata_r <= 32'd0;
    end else begin
      case (state_next_s)
        ACC1: begin
          dm_req_r   <= 1'b1;
          dm_w_en_r  <= src_store_s;
          dm_addr_r  <= word_addr_s;
          dm_be_r    <= src_store_s ? be8_s[3:0] : 4'b1111;
          dm_wdata_r <= src_store_s ? wd64_s[31:0] : 32'd0;
        end
        ACC2: begin
          dm_req_r   <= 1'b1;
          dm_w_en_r  <= src_store_s;
          dm_addr_r  <= word_addr_s + ADDR_WIDTH'(3'd4);
          dm_be_r    <= src_store_s ? be8_s[7:4] : 4'b1111;
          dm_wdata_r <= src_store_s ? wd64_s[63:32] : 32'd0;
        end
        default: begin
          dm_req_r   <= 1'b0;
          dm_w_en_r  <= 1'b0;
          dm_addr_r  <= '0;
          dm_be_r    <= 4'b0000;
          dm_wdata_r <= 32'd0;
        end
      endcase
    end
  end

  load_data_formatter u_formatter (
    .hi          (hi_r),
    .lo          (lo_r),
    .off         (addr_r[1:0]),
    .mem_control (mc_r),
    .data        (fmt_data_s)
  );

  // Completion pulse and result; stores and skipped accesses return 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lsu_done_r <= 1'b0;
      lsu_mis_r  <= 1'b0;
      data_out_r <= 32'd0;
    end else if (state_r == DONE) begin
      lsu_done_r <= 1'b1;
      lsu_mis_r  <= skip_r & misal_r;
      data_out_r <= (!store_r && !skip_r) ? fmt_data_s : 32'd0;
    end else begin
      lsu_done_r <= 1'b0;
      lsu_mis_r  <= 1'b0;
      data_out_r <= 32'd0;
    end
  end

  assign LSU_Busy       = LSU_Req & ~lsu_done_r;
  assign LSU_Done       = lsu_done_r;
  assign LSU_Misaligned = lsu_mis_r;
  assign Data_Out       = data_out_r;
  assign DM_Req         = dm_req_r;
  assign DM_W_En        = dm_w_en_r;
  assign DM_Addr        = dm_addr_r;
  assign DM_Byte_En     = dm_be_r;
  assign DM_W_Data      = dm_wdata_r;

endmodule
